// File: rtl/bufgce_div_checker.sv
// -----------------------------------------------------------------------------
// bufgce_div_checker
//
// Receiving-end monitor for a divided clock produced by a BUFGCE_DIV-style
// divider. DIV_CLK is sampled as plain data in the undivided CLK domain. Its
// period and high time are measured in CLK cycles and checked against the
// expected divide ratio. The block reports lock, per-error pulses, the cause
// of the last error and a saturating error count.
//
// Optional feature macro: CHECKER_DUTY_EN
//   defined   -> the high time is part of the evaluation (error code 10 possible)
//   undefined -> only period and stall are checked; HIGH_CNT is still reported
//
// Parameters
//   EXP_DIVIDE  expected divide ratio (2..8); expected high time = EXP_DIVIDE/2
//   LOCK_COUNT  consecutive good periods needed before LOCKED (1..15)
//   STALL_LIMIT CLK cycles without a DIV_CLK rise before a stall (9..15)
//
// Ports
//   CLK       in   undivided source clock, rising edge
//   RST       in   asynchronous active-high reset
//   ENABLE    in   check enable; low = divider intentionally gated, checker idles
//   DIV_CLK   in   divided clock under test, treated as synchronous data
//   LOCKED    out  LOCK_COUNT consecutive good periods since last error/enable
//   ERR       out  one-cycle pulse per detected error
//   ERR_CODE  out  cause of last error: 01 period, 10 duty, 11 stall (held)
//   PERIOD    out  last measured period in CLK cycles
//   HIGH_CNT  out  last measured high time in CLK cycles
//   ERR_CNT   out  saturating error count (stops at 255)
// -----------------------------------------------------------------------------
module bufgce_div_checker #(
  parameter int unsigned EXP_DIVIDE  = 4,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned STALL_LIMIT = 15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ENABLE,
  input  logic       DIV_CLK,
  output logic       LOCKED,
  output logic       ERR,
  output logic [1:0] ERR_CODE,
  output logic [3:0] PERIOD,
  output logic [3:0] HIGH_CNT,
  output logic [7:0] ERR_CNT
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_RUN   = 2'd2,
    ST_STALL = 2'd3
  } state_t;

  localparam logic [3:0] EXP_PERIOD  = 4'(EXP_DIVIDE);
  localparam logic [3:0] LOCK_TGT    = 4'(LOCK_COUNT);
  localparam logic [3:0] STALL_CNT   = 4'(STALL_LIMIT);
  localparam logic [3:0] CNT_MAX     = 4'd15;
  localparam logic [7:0] ERRCNT_MAX  = 8'hFF;
  localparam logic [1:0] CODE_PERIOD = 2'b01;
  localparam logic [1:0] CODE_STALL  = 2'b11;

  state_t     state_q, state_d;
  logic       prev_q;
  logic [3:0] cnt_q, cnt_d;         // cycles since last rise
  logic [3:0] hcnt_q, hcnt_d;       // cycles DIV_CLK has been high since last rise
  logic       hpend_q, hpend_d;     // a rise was seen and its fall is not yet captured
  logic [3:0] good_q, good_d;       // consecutive good periods (saturates at LOCK_TGT)
  logic       locked_q, locked_d;
  logic       err_q, err_d;
  logic [1:0] code_q, code_d;
  logic [3:0] period_q, period_d;
  logic [3:0] high_q, high_d;
  logic [7:0] errcnt_q, errcnt_d;

  logic       rise;
  logic       fall;
  logic       duty_bad;
  logic       raise;
  logic [1:0] raise_code;

  assign rise = DIV_CLK & ~prev_q;
  assign fall = ~DIV_CLK & prev_q;

  // The high time of the period that just closed was captured at its fall,
  // which always precedes the closing rise by at least one cycle.
`ifdef CHECKER_DUTY_EN
  localparam logic [3:0] EXP_HIGH  = 4'(EXP_DIVIDE / 2);
  localparam logic [1:0] CODE_DUTY = 2'b10;
  assign duty_bad = (high_q != EXP_HIGH);
`else
  assign duty_bad = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hcnt_d     = hcnt_q;
    hpend_d    = hpend_q;
    good_d     = good_q;
    locked_d   = locked_q;
    err_d      = 1'b0;
    code_d     = code_q;
    period_d   = period_q;
    high_d     = high_q;
    errcnt_d   = errcnt_q;
    raise      = 1'b0;
    raise_code = 2'b00;

    // Measurement counters: cleared while idle, free-running otherwise.
    if (state_q == ST_IDLE) begin
      cnt_d   = 4'd0;
      hcnt_d  = 4'd0;
      hpend_d = 1'b0;
    end else if (rise) begin
      cnt_d    = 4'd1;
      hcnt_d   = 4'd1;
      hpend_d  = 1'b1;
      period_d = cnt_q;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 4'd1;
      if (DIV_CLK && (hcnt_q != CNT_MAX)) hcnt_d = hcnt_q + 4'd1;
      if (fall && hpend_q) begin
        high_d  = hcnt_q;
        hpend_d = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        good_d   = 4'd0;
        locked_d = 1'b0;
        if (ENABLE) state_d = ST_SYNC;
      end
      // The partial period before the first rise is never evaluated.
      ST_SYNC: begin
        if (rise) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (rise) begin
          // Period error takes priority over a simultaneous duty error.
          if (cnt_q != EXP_PERIOD) begin
            raise      = 1'b1;
            raise_code = CODE_PERIOD;
`ifdef CHECKER_DUTY_EN
          end else if (duty_bad) begin
            raise      = 1'b1;
            raise_code = CODE_DUTY;
`endif
          end else begin
            if (good_q != LOCK_TGT) good_d = good_q + 4'd1;
            locked_d = (good_d == LOCK_TGT);
          end
        end else if (cnt_q >= STALL_CNT) begin
          // Covers both a missing rise and a missing fall (cnt keeps counting).
          raise      = 1'b1;
          raise_code = CODE_STALL;
          state_d    = ST_STALL;
        end
      end
      // Resume on the next rise; the period it closes is not evaluated.
      ST_STALL: begin
        locked_d = 1'b0;
        if (rise) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase

    if (raise && ENABLE) begin
      err_d    = 1'b1;
      code_d   = raise_code;
      good_d   = 4'd0;
      locked_d = 1'b0;
      if (errcnt_q != ERRCNT_MAX) errcnt_d = errcnt_q + 8'd1;
    end

    // A gated divider is intentional: drop to idle silently.
    if (!ENABLE) begin
      state_d  = ST_IDLE;
      good_d   = 4'd0;
      locked_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      prev_q   <= 1'b0;
      cnt_q    <= 4'd0;
      hcnt_q   <= 4'd0;
      hpend_q  <= 1'b0;
      good_q   <= 4'd0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 2'b00;
      period_q <= 4'd0;
      high_q   <= 4'd0;
      errcnt_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      prev_q   <= DIV_CLK;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      hpend_q  <= hpend_d;
      good_q   <= good_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      code_q   <= code_d;
      period_q <= period_d;
      high_q   <= high_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign LOCKED   = locked_q;
  assign ERR      = err_q;
  assign ERR_CODE = code_q;
  assign PERIOD   = period_q;
  assign HIGH_CNT = high_q;
  assign ERR_CNT  = errcnt_q;

endmodule

// File: tb/tb_bufgce_div_checker.sv
// -----------------------------------------------------------------------------
// tb_bufgce_div_checker
//
// Directed bench for bufgce_div_checker. A timestamp-based reference model
// predicts every output after every CLK edge; each cycle all outputs are
// compared, and hand-computed literal expectations pin the model at key
// points of each scenario.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bufgce_div_checker;

  localparam int EXP   = 4;
  localparam int LOCK  = 4;
  localparam int STALL = 15;
`ifdef CHECKER_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       div_clk;
  logic       locked;
  logic       err;
  logic [1:0] err_code;
  logic [3:0] period;
  logic [3:0] high_cnt;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;

  bufgce_div_checker #(
    .EXP_DIVIDE (EXP),
    .LOCK_COUNT (LOCK),
    .STALL_LIMIT(STALL)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .ENABLE  (enable),
    .DIV_CLK (div_clk),
    .LOCKED  (locked),
    .ERR     (err),
    .ERR_CODE(err_code),
    .PERIOD  (period),
    .HIGH_CNT(high_cnt),
    .ERR_CNT (err_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (timestamps, not counters) -------------
  int cyc = 0;
  bit m_on, m_sync, m_stall, m_hpend, m_prev;
  int m_rise_t, m_good;
  bit e_locked, e_err;
  int e_code, e_period, e_high, e_errcnt;

  task automatic model_reset();
    m_on = 0; m_sync = 0; m_stall = 0; m_hpend = 0; m_prev = 0;
    m_rise_t = 0; m_good = 0;
    e_locked = 0; e_err = 0; e_code = 0; e_period = 0; e_high = 0; e_errcnt = 0;
  endtask

  task automatic model_error(input int code);
    e_err = 1;
    e_code = code;
    if (e_errcnt < 255) e_errcnt++;
    m_good = 0;
    e_locked = 0;
  endtask

  // Called once per CLK rising edge with the inputs that edge samples.
  task automatic model_step();
    bit rise, fall;
    int since;
    if (rst) begin
      model_reset();
      return;
    end
    cyc++;
    rise  = div_clk && !m_prev;
    fall  = !div_clk && m_prev;
    e_err = 0;
    if (!m_on) begin
      m_hpend = 0; m_good = 0; e_locked = 0;
      // Counting restarts from zero one edge after enable is seen.
      if (enable) begin m_on = 1; m_sync = 0; m_stall = 0; m_rise_t = cyc + 1; end
    end else begin
      since = cyc - m_rise_t;
      if (since > 15) since = 15;
      if (rise) e_period = since;
      if (fall && m_hpend) begin e_high = since; m_hpend = 0; end
      if (!enable) begin
        m_on = 0; m_good = 0; e_locked = 0;
      end else if (!m_sync) begin
        m_sync = rise;
      end else if (m_stall) begin
        m_stall = !rise;
      end else if (rise) begin
        if (since != EXP) model_error(1);
        else if (DUTY && e_high != EXP / 2) model_error(2);
        else begin
          if (m_good < LOCK) m_good++;
          e_locked = (m_good == LOCK);
        end
      end else if (since >= STALL) begin
        m_stall = 1;
        model_error(3);
      end
      if (rise) begin m_rise_t = cyc; m_hpend = 1; end
    end
    m_prev = div_clk;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    check("cyc LOCKED",   int'(locked),   int'(e_locked));
    check("cyc ERR",      int'(err),      int'(e_err));
    check("cyc ERR_CODE", int'(err_code), e_code);
    check("cyc PERIOD",   int'(period),   e_period);
    check("cyc HIGH_CNT", int'(high_cnt), e_high);
    check("cyc ERR_CNT",  int'(err_cnt),  e_errcnt);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " LOCKED"},   int'(locked),   0);
    check({tag, " ERR"},      int'(err),      0);
    check({tag, " ERR_CODE"}, int'(err_code), 0);
    check({tag, " PERIOD"},   int'(period),   0);
    check({tag, " HIGH_CNT"}, int'(high_cnt), 0);
    check({tag, " ERR_CNT"},  int'(err_cnt),  0);
  endtask

  // One CLK cycle: the value driven here is sampled by the next rising edge.
  task automatic tick(input logic v);
    @(posedge clk);
    model_step();
    #2;
    div_clk = v;
    @(negedge clk);
    compare_all();
  endtask

  task automatic per(input int hi, input int lo);
    repeat (hi) tick(1'b1);
    repeat (lo) tick(1'b0);
    $display("[%0t] period hi=%0d lo=%0d en=%0d -> PERIOD=%0d HIGH_CNT=%0d LOCKED=%0d ERR_CODE=%0d ERR_CNT=%0d",
             $time, hi, lo, enable, period, high_cnt, locked, err_code, err_cnt);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    rst = 1'b1; enable = 1'b0; div_clk = 1'b0;
    tick(1'b0);
    tick(1'b0);
    check_zero("reset");
    rst = 1'b0;
    enable = 1'b1;
    tick(1'b0);
    tick(1'b0);

    // 1: clean divide-by-4
    repeat (8) per(2, 2);
    check("t1 PERIOD", int'(period), 4);
    check("t1 HIGH_CNT", int'(high_cnt), 2);
    check("t1 LOCKED", int'(locked), 1);
    check("t1 ERR_CNT", int'(err_cnt), 0);

    // 2: one period of 5 while locked, then relock after 4 good periods
    per(3, 2);
    per(2, 2);
    check("t2 PERIOD", int'(period), 5);
    check("t2 ERR_CODE", int'(err_code), 1);
    check("t2 ERR_CNT", int'(err_cnt), 1);
    check("t2 LOCKED", int'(locked), 0);
    repeat (3) per(2, 2);
    check("t2 LOCKED after 3 good", int'(locked), 0);
    per(2, 2);
    check("t2 LOCKED after 4 good", int'(locked), 1);

    // 3: DIV_CLK held low for 20 cycles
    repeat (20) tick(1'b0);
    check("t3 ERR_CODE", int'(err_code), 3);
    check("t3 ERR_CNT", int'(err_cnt), 2);
    check("t3 LOCKED", int'(locked), 0);
    per(2, 2);
    check("t3 resume PERIOD", int'(period), 15);
    check("t3 resume ERR_CNT", int'(err_cnt), 2);
    repeat (4) per(2, 2);
    check("t3 relock", int'(locked), 1);

    // 4: period 4 with high 3 / low 1
    per(3, 1);
    tick(1'b1);
    check("t4 HIGH_CNT", int'(high_cnt), 3);
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    check("t4 PERIOD", int'(period), 4);
`ifdef CHECKER_DUTY_EN
    check("t4 ERR_CODE", int'(err_code), 2);
    check("t4 ERR_CNT", int'(err_cnt), 3);
    check("t4 LOCKED", int'(locked), 0);
`else
    check("t4 ERR_CODE", int'(err_code), 3);
    check("t4 ERR_CNT", int'(err_cnt), 2);
    check("t4 LOCKED", int'(locked), 1);
`endif

    // 5: ENABLE dropped while locked with DIV_CLK stopped, then re-enabled
    repeat (5) per(2, 2);
    check("t5 LOCKED before drop", int'(locked), 1);
    enable = 1'b0;
    tick(1'b0);
    check("t5 LOCKED next cycle", int'(locked), 0);
    repeat (19) tick(1'b0);
    check("t5 LOCKED idle", int'(locked), 0);
    check("t5 ERR_CNT idle", int'(err_cnt), DUTY ? 3 : 2);
    enable = 1'b1;
    repeat (6) per(2, 2);
    check("t5 relock", int'(locked), 1);

    // 6: reset mid-period with ERR_CNT=3, then error-count saturation
`ifndef CHECKER_DUTY_EN
    per(3, 2);
    per(2, 2);
`endif
    check("t6 ERR_CNT before reset", int'(err_cnt), 3);
    tick(1'b1);
    #1 rst = 1'b1;
    model_reset();
    #1 check_zero("t6 mid reset");
    @(posedge clk);
    #2;
    rst = 1'b0;
    div_clk = 1'b0;
    tick(1'b0);
    tick(1'b0);
    repeat (262) per(1, 2);
    check("t6 ERR_CNT saturated", int'(err_cnt), 255);
    check("t6 ERR_CODE priority", int'(err_code), 1);
    check("t6 LOCKED", int'(locked), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
